// File: rtl/morph_filter.sv
// morph_filter
// Binary morphological erosion/dilation over a KSIZE x KSIZE square kernel,
// applied to a raster pixel stream. Each input sample is binarised against
// THRESH, stored in KSIZE-1 single-bit line buffers and shifted into a
// KSIZE x KSIZE window. The filtered pixel for centre (h-R, v-R) appears two
// clocks after input sample (h, v).
//
// Ports:
//   clock        sole clock, rising edge
//   reset        asynchronous, active-high
//   hcount       input pixel column (11 bits)
//   vcount       input pixel row (10 bits)
//   color        input pixel intensity (8 bits)
//   mode         0 = erosion, 1 = dilation (latched at start of frame)
//   pixel        filtered binary pixel
//   pixel_valid  pixel/out_hcount/out_vcount valid this cycle
//   out_hcount   column of the filtered pixel (holds while not valid)
//   out_vcount   row of the filtered pixel (holds while not valid)

module morph_filter #(
    parameter int         H_ACTIVE = 1024,
    parameter int         V_ACTIVE = 768,
    parameter int         KSIZE    = 3,
    parameter logic [7:0] THRESH   = 8'hFF
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [10:0] hcount,
    input  logic [9:0]  vcount,
    input  logic [7:0]  color,
    input  logic        mode,
    output logic        pixel,
    output logic        pixel_valid,
    output logic [10:0] out_hcount,
    output logic [9:0]  out_vcount
);

    localparam int R   = (KSIZE - 1) / 2;
    localparam int NLB = KSIZE - 1;
    localparam int HW  = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;

    localparam logic [10:0] H_LAST    = 11'(H_ACTIVE - 1);
    localparam logic [9:0]  V_LAST    = 10'(V_ACTIVE - 1);
    localparam logic [10:0] R_H       = 11'(R);
    localparam logic [9:0]  R_V       = 10'(R);
    localparam logic [9:0]  FILL_LAST = 10'(R - 1);
    // Erosion border limits expressed in input coordinates (centre = input - R)
    localparam logic [10:0] H_EDGE_LO = 11'(2 * R);
    localparam logic [9:0]  V_EDGE_LO = 10'(2 * R);
    localparam logic [10:0] H_EDGE_HI = 11'(H_ACTIVE - 1 - R);
    localparam logic [9:0]  V_EDGE_HI = 10'(V_ACTIVE - 1 - R);

    typedef enum logic [1:0] {
        WAIT_SOF,
        FILL,
        RUN
    } state_t;

    state_t state;
    logic   frame_mode;

    logic active;
    logic sof;
    logic flush;
    logic fg;
    logic shift_en;
    logic run_sample;

    logic [HW-1:0]    hidx;
    logic [NLB-1:0]   col_prev;
    logic [KSIZE-1:0] new_col;

    // Column-organised line store: bit k of an entry holds the sample from
    // k+1 lines above the current one at that column.
    logic [NLB-1:0]   line_mem [H_ACTIVE];

    // window[j] is the column j samples to the left of the newest one;
    // bit k of a column is the sample k lines above the newest row.
    logic [KSIZE-1:0] window [KSIZE];

    logic        s1_valid;
    logic [10:0] s1_h;
    logic [9:0]  s1_v;

    logic and_all;
    logic or_all;
    logic near_edge;
    logic result;

    assign active     = (hcount <= H_LAST) && (vcount <= V_LAST);
    assign sof        = active && (hcount == '0) && (vcount == '0);
    assign flush      = sof && (state != WAIT_SOF);
    assign fg         = (color >= THRESH);
    assign shift_en   = active && ((state != WAIT_SOF) || sof);
    assign run_sample = active && (state == RUN) && !sof &&
                        (hcount >= R_H) && (vcount >= R_V);
    assign hidx       = hcount[HW-1:0];
    assign col_prev   = line_mem[hidx];
    assign new_col    = {col_prev, fg};

    // Frame sequencing. A start-of-frame sample always (re)starts filling and
    // captures the operating mode for the whole frame, which also abandons
    // any frame still in progress.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= WAIT_SOF;
            frame_mode <= 1'b0;
        end else if (sof) begin
            state      <= FILL;
            frame_mode <= mode;
        end else begin
            case (state)
                WAIT_SOF: state <= WAIT_SOF;
                FILL: begin
                    if (active && (hcount == H_LAST) && (vcount == FILL_LAST))
                        state <= RUN;
                end
                RUN: begin
                    if (active && (hcount == H_LAST) && (vcount == V_LAST))
                        state <= WAIT_SOF;
                end
                default: state <= WAIT_SOF;
            endcase
        end
    end

    // Line store is never cleared: the fill phase rewrites every column of
    // the rows it will be read back for before any output is produced.
    // The read above sees the old column, so each line moves down one slot.
    always_ff @(posedge clock) begin
        if (shift_en)
            line_mem[hidx] <= {col_prev[NLB-2:0], fg};
    end

    // Window shift plus the first pipeline stage, which remembers where the
    // newest window column sits so the second stage can locate the centre.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int j = 0; j < KSIZE; j++)
                window[j] <= '0;
            s1_valid <= 1'b0;
            s1_h     <= '0;
            s1_v     <= '0;
        end else begin
            if (shift_en) begin
                window[0] <= new_col;
                for (int j = 1; j < KSIZE; j++)
                    window[j] <= window[j-1];
            end
            s1_valid <= run_sample;
            if (run_sample) begin
                s1_h <= hcount;
                s1_v <= vcount;
            end
        end
    end

    // Kernel reduction. Window cells left of column 0 or above row 0 hold
    // stale data from the previous line/frame, so dilation masks them out;
    // erosion near any border is forced to 0 and needs no mask.
    always_comb begin
        and_all = 1'b1;
        or_all  = 1'b0;
        for (int j = 0; j < KSIZE; j++) begin
            for (int k = 0; k < KSIZE; k++) begin
                and_all = and_all & window[j][k];
                if ((s1_h >= 11'(j)) && (s1_v >= 10'(k)))
                    or_all = or_all | window[j][k];
            end
        end
        near_edge = (s1_h < H_EDGE_LO) || (s1_v < V_EDGE_LO) ||
                    (s1_h > H_EDGE_HI) || (s1_v > V_EDGE_HI);
        result    = frame_mode ? or_all : (and_all && !near_edge);
    end

    // Output stage. A restart flushes the result that would otherwise
    // emerge this cycle; coordinates hold whenever nothing valid is issued.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pixel       <= 1'b0;
            pixel_valid <= 1'b0;
            out_hcount  <= '0;
            out_vcount  <= '0;
        end else begin
            pixel_valid <= s1_valid && !flush;
            pixel       <= s1_valid && !flush && result;
            if (s1_valid && !flush) begin
                out_hcount <= s1_h - R_H;
                out_vcount <= s1_v - R_V;
            end
        end
    end

endmodule
